uart_debug_cpu: RTL and testbench
=================================

Name: uart_debug_cpu

Overview:
- Self-contained top-level for a UART-driven program loader and tiny MIPS-subset executor.
- A host sends a load command plus big-endian 32-bit instruction words over serial RX; a run command then executes the stored program.
- After execution, the block dumps the register file back over serial TX.
- Sits at FPGA top level, directly on the board UART pins.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 9600, UART bit rate. Bit period is CLK_FREQ/BAUD clocks (10416 at defaults), 8N1, LSB first.
- IMEM_DEPTH, 64, number of 32-bit instruction memory words.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (reset==0 resets).
- rx  input  1  UART serial input, idle high; passes through a 2-flop synchronizer.
- o_tx  output  1  UART serial output, idle high.

Behaviour:
- Reset: o_tx=1, state=IDLE, load address=0, PC=0, all 32 registers=0, instruction memory contents undefined.
- UART RX:
  - Falling edge on synchronized rx starts a frame.
  - Sample at mid-bit: start bit rechecked at half period (aborts if high), then 8 data bits, then stop bit.
  - Stop bit low means framing error: byte discarded.
  - Valid byte raises a one-cycle rx_valid.
- UART TX:
  - Accepts a byte only when idle.
  - Sends start bit, 8 data bits LSB first, then 1 stop bit, each one bit period long.
  - tx_busy stays high throughout the frame.
- IDLE state:
  - 0x6C ('l') goes to LOAD and sets load address=0.
  - 0x72 ('r') goes to RUN and sets PC=0. Registers are not cleared.
  - Any other byte is ignored.
- LOAD state:
  - Bytes are assembled MSB first; 4 bytes form a word.
  - Each word is written to imem[addr], then addr increments.
  - Word 0xFFFFFFFF (HALT) is also stored, then the state returns to IDLE.
  - Words with addr ≥ IMEM_DEPTH are dropped, but HALT still ends LOAD.
- RUN state:
  - Executes one instruction per clock: fetch imem[PC] (combinational read), execute, PC+1.
  - Decode rules:
    - LUI (op 0x0F): rt = imm<<16.
    - ADDIU/ADDI (op 0x09/0x08): rt = rs + sign-extended imm, no overflow trap.
    - ORI (0x0D) and ANDI (0x0C): zero-extended imm.
    - R-type (op 0) by funct:
      - 0x20/0x21: add, wrapping mod 2^32.
      - 0x23: subu.
      - 0x24: and.
      - 0x25: or.
      - 0x26: xor.
      - 0x2A: signed slt.
    - Any other encoding executes as a NOP.
  - Writes to r0 are ignored; r0 always reads 0.
  - HALT word, or PC reaching IMEM_DEPTH, goes to DUMP.
  - rx bytes arriving during RUN/DUMP are ignored.
- DUMP state:
  - Transmits r0..r31, each big-endian (byte3 first): 128 bytes back-to-back.
  - The next byte is issued the cycle after tx_busy falls.
  - After the last stop bit, returns to IDLE.
- A reset asserted mid-operation aborts any frame immediately: o_tx=1, state=IDLE.

Decomposition:
- Shared package uart_debug_pkg holds:
  - Command constants CMD_LOAD=8'h6C and CMD_RUN=8'h72.
  - HALT_WORD=32'hFFFFFFFF.
  - Opcode/funct localparams.
  - State enum IDLE/LOAD/RUN/DUMP.
- One natural sub-module, uart_phy: RX+TX with baud counters, exposing rx_data/rx_valid and tx_data/tx_start/tx_busy.
- Control FSM, instruction memory, register file and ALU stay in uart_debug_cpu.

Test Plan:
- Reset: hold reset=0 for 100 ns -> o_tx=1 continuously, no frames emitted.
- Load and run:
  - Send 6C, then 3C 01 00 01, 3C 02 00 01, 00 22 18 21, FF FF FF FF, then 72.
  - Required dump: 00 00 00 00, 00 01 00 00, 00 01 00 00, 00 02 00 00, then 112 bytes of 00.
  - Each byte is framed with a 104.17 µs bit period.
- Framing error: send 0x72 with the stop bit driven low -> no dump, state stays IDLE. A following valid 0x72 then triggers the dump.
- Unknown command: send 0x41 then 0x72 (no prior load, memory empty/X) -> 0x41 ignored. After reset plus load of FF FF FF FF only, run dumps 128 bytes of 00.
- Arithmetic wrap: load 24 01 FF FF (addiu r1,r0,-1), 24 22 00 01 (addiu r2,r1,1), 00 01 18 2A (slt r3,r0,r1), HALT -> r1=FFFFFFFF, r2=00000000, r3=00000000.
- Overflow: load 70 non-HALT words then HALT, then run -> words 64..69 dropped, execution stops at PC=64, dump follows normally.

Source files
------------

// File: rtl/uart_debug_pkg.sv
// rtl/uart_debug_pkg.sv - shared constants, opcodes and state types for the UART debug CPU
package uart_debug_pkg;

    localparam logic [7:0]  CMD_LOAD  = 8'h6C;
    localparam logic [7:0]  CMD_RUN   = 8'h72;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DUMP} state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_phy.sv
// rtl/uart_phy.sv - 8N1 UART receiver and transmitter with baud counters
// Ports: clk, reset (async active-low), rx (serial in), tx (serial out),
//        rx_data/rx_valid (received byte, one-cycle strobe),
//        tx_data/tx_start/tx_busy (byte accepted only while tx_busy is low).
module uart_phy
    import uart_debug_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       tx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy
);

    localparam int BIT  = CLK_FREQ / BAUD;
    localparam int HALF = BIT / 2;
    localparam int CW   = $clog2(BIT + 1);

    logic            rx_s1, rx_s2, rx_prev;
    rx_state_t       rx_st, rx_st_n;
    logic [CW-1:0]   rx_cnt, rx_cnt_n;
    logic [2:0]      rx_idx, rx_idx_n;
    logic [7:0]      rx_sh, rx_sh_n;
    logic            rx_valid_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_st    <= RX_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_sh    <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_s1    <= rx;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_st    <= rx_st_n;
            rx_cnt   <= rx_cnt_n;
            rx_idx   <= rx_idx_n;
            rx_sh    <= rx_sh_n;
            rx_valid <= rx_valid_n;
        end
    end

    always_comb begin
        rx_st_n    = rx_st;
        rx_cnt_n   = rx_cnt + 1'b1;
        rx_idx_n   = rx_idx;
        rx_sh_n    = rx_sh;
        rx_valid_n = 1'b0;
        case (rx_st)
            RX_IDLE: begin
                rx_cnt_n = '0;
                if (rx_prev && !rx_s2) rx_st_n = RX_START;
            end
            RX_START: if (rx_cnt == CW'(HALF - 1)) begin
                // Line back high at mid start bit means a glitch, not a frame.
                rx_cnt_n = '0;
                rx_idx_n = '0;
                rx_st_n  = rx_s2 ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt == CW'(BIT - 1)) begin
                rx_cnt_n = '0;
                rx_sh_n  = {rx_s2, rx_sh[7:1]};
                rx_idx_n = rx_idx + 1'b1;
                if (rx_idx == 3'd7) rx_st_n = RX_STOP;
            end
            RX_STOP: if (rx_cnt == CW'(BIT - 1)) begin
                // A low stop bit is a framing error: the byte is dropped.
                rx_cnt_n   = '0;
                rx_valid_n = rx_s2;
                rx_st_n    = RX_IDLE;
            end
            default: rx_st_n = RX_IDLE;
        endcase
    end

    assign rx_data = rx_sh;

    logic [8:0]    tx_sh;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_idx;

    // tx_idx counts finished bit periods: 0 start, 1..8 data, 9 stop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_busy <= 1'b0;
            tx      <= 1'b1;
            tx_sh   <= '0;
            tx_cnt  <= '0;
            tx_idx  <= '0;
        end else if (!tx_busy) begin
            tx <= 1'b1;
            if (tx_start) begin
                tx_busy <= 1'b1;
                tx      <= 1'b0;
                tx_sh   <= {1'b1, tx_data};
                tx_cnt  <= '0;
                tx_idx  <= '0;
            end
        end else if (tx_cnt == CW'(BIT - 1)) begin
            tx_cnt <= '0;
            if (tx_idx == 4'd9) begin
                tx_busy <= 1'b0;
            end else begin
                tx     <= tx_sh[0];
                tx_sh  <= {1'b1, tx_sh[8:1]};
                tx_idx <= tx_idx + 1'b1;
            end
        end else begin
            tx_cnt <= tx_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_debug_cpu.sv
// rtl/uart_debug_cpu.sv - UART program loader, MIPS-subset executor and register dumper
// Ports: clk, reset (async active-low), rx (UART in, idle high), o_tx (UART out, idle high).
module uart_debug_cpu
    import uart_debug_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int IMEM_DEPTH = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic o_tx
);

    localparam int IW = $clog2(IMEM_DEPTH);
    localparam int AW = IW + 1;
    localparam logic [AW-1:0] DEPTH_A = AW'(IMEM_DEPTH);

    logic [7:0] rx_data, tx_data;
    logic       rx_valid, tx_start, tx_busy;

    uart_phy #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_phy (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .tx       (o_tx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy)
    );

    state_t        state, state_n;
    logic [AW-1:0] addr, pc;
    logic [1:0]    byte_cnt;
    logic [23:0]   word_sh;
    logic [7:0]    dump_idx;
    logic [31:0]   regs [32];
    logic [31:0]   imem [IMEM_DEPTH];

    logic [31:0] load_word, instr, rs_val, rt_val, sext, wr_val, dump_word;
    logic [4:0]  wr_idx;
    logic        wr_en, stop_run;

    assign load_word = {word_sh, rx_data};
    assign instr     = imem[pc[IW-1:0]];
    assign stop_run  = (pc == DEPTH_A) || (instr == HALT_WORD);
    assign rs_val    = regs[instr[25:21]];
    assign rt_val    = regs[instr[20:16]];
    assign sext      = {{16{instr[15]}}, instr[15:0]};

    always_comb begin
        wr_en  = 1'b1;
        wr_idx = instr[20:16];
        wr_val = '0;
        case (instr[31:26])
            OP_LUI:           wr_val = {instr[15:0], 16'h0000};
            OP_ADDI, OP_ADDIU: wr_val = rs_val + sext;
            OP_ORI:           wr_val = rs_val | {16'h0000, instr[15:0]};
            OP_ANDI:          wr_val = rs_val & {16'h0000, instr[15:0]};
            OP_RTYPE: begin
                wr_idx = instr[15:11];
                case (instr[5:0])
                    FN_ADD, FN_ADDU: wr_val = rs_val + rt_val;
                    FN_SUBU:         wr_val = rs_val - rt_val;
                    FN_AND:          wr_val = rs_val & rt_val;
                    FN_OR:           wr_val = rs_val | rt_val;
                    FN_XOR:          wr_val = rs_val ^ rt_val;
                    FN_SLT:          wr_val = {31'd0, $signed(rs_val) < $signed(rt_val)};
                    default:         wr_en  = 1'b0;
                endcase
            end
            default: wr_en = 1'b0;
        endcase
        // r0 is never written, so reading it always yields zero.
        if (wr_idx == 5'd0) wr_en = 1'b0;
    end

    always_comb begin
        dump_word = regs[dump_idx[6:2]];
        case (dump_idx[1:0])
            2'd0:    tx_data = dump_word[31:24];
            2'd1:    tx_data = dump_word[23:16];
            2'd2:    tx_data = dump_word[15:8];
            default: tx_data = dump_word[7:0];
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n  = state;
        tx_start = 1'b0;
        case (state)
            IDLE: if (rx_valid) begin
                if (rx_data == CMD_LOAD)     state_n = LOAD;
                else if (rx_data == CMD_RUN) state_n = RUN;
            end
            LOAD: if (rx_valid && byte_cnt == 2'd3 && load_word == HALT_WORD) state_n = IDLE;
            RUN:  if (stop_run) state_n = DUMP;
            DUMP: begin
                // All 128 bytes issued: leave once the last frame's stop bit ends.
                if (dump_idx == 8'd128) begin
                    if (!tx_busy) state_n = IDLE;
                end else begin
                    tx_start = !tx_busy;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr     <= '0;
            pc       <= '0;
            byte_cnt <= '0;
            word_sh  <= '0;
            dump_idx <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    dump_idx <= '0;
                    if (rx_valid && rx_data == CMD_LOAD) begin
                        addr     <= '0;
                        byte_cnt <= '0;
                    end
                    if (rx_valid && rx_data == CMD_RUN) pc <= '0;
                end
                LOAD: if (rx_valid) begin
                    byte_cnt <= byte_cnt + 1'b1;
                    word_sh  <= {word_sh[15:0], rx_data};
                    // Saturate at the depth so overflow words keep being dropped.
                    if (byte_cnt == 2'd3 && addr < DEPTH_A) addr <= addr + 1'b1;
                end
                RUN: if (!stop_run) begin
                    pc <= pc + 1'b1;
                    if (wr_en) regs[wr_idx] <= wr_val;
                end
                DUMP: if (tx_start) dump_idx <= dump_idx + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == LOAD && rx_valid && byte_cnt == 2'd3 && addr < DEPTH_A)
            imem[addr[IW-1:0]] <= load_word;
    end

endmodule

// File: tb/tb_uart_debug_cpu.sv
// tb/tb_uart_debug_cpu.sv - scoreboard bench for uart_debug_cpu
module tb_uart_debug_cpu;

    localparam int CLK_FREQ = 40;
    localparam int BAUD     = 10;
    localparam int BIT      = CLK_FREQ / BAUD;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rx = 1'b1;
    logic o_tx;

    always #5 clk = ~clk;

    uart_debug_cpu #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .IMEM_DEPTH(64)) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .o_tx  (o_tx)
    );

    int         vectors = 0;
    int         miscompares = 0;
    int         frames_seen = 0;
    logic [7:0] exp_q [$];

    logic [7:0] mon_byte, mon_exp;
    logic       mon_stop;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (reset && o_tx == 1'b0) begin
                repeat (BIT / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk);
                    mon_byte[i] = o_tx;
                end
                repeat (BIT) @(negedge clk);
                mon_stop = o_tx;
                frames_seen++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_tx_byte: got %02h, no byte expected", mon_byte);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_byte !== mon_exp || mon_stop !== 1'b1) begin
                        miscompares++;
                        $display("FAIL dump_byte: got %02h stop=%0b, expected %02h stop=1",
                                 mon_byte, mon_stop, mon_exp);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stop;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24], 1'b1);
        send_byte(w[23:16], 1'b1);
        send_byte(w[15:8], 1'b1);
        send_byte(w[7:0], 1'b1);
    endtask

    task automatic push_dump(input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] r3);
        logic [31:0] w;
        for (int r = 0; r < 32; r++) begin
            w = (r == 1) ? r1 : (r == 2) ? r2 : (r == 3) ? r3 : 32'h0;
            exp_q.push_back(w[31:24]);
            exp_q.push_back(w[23:16]);
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 8000 && exp_q.size() != 0; i++) @(negedge clk);
        check(name, exp_q.size(), 0);
        exp_q.delete();
        repeat (4 * BIT) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx_idle", o_tx, 1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    int f0;

    initial begin : stimulus
        reset = 1'b0;
        rx    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("reset_hold_tx", o_tx, 1);
        end
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // Load lui/lui/addu program and run it.
        send_byte(8'h6C, 1'b1);
        send_word(32'h3C01_0001);
        send_word(32'h3C02_0001);
        send_word(32'h0022_1821);
        send_word(32'hFFFF_FFFF);
        push_dump(32'h0001_0000, 32'h0001_0000, 32'h0002_0000);
        send_byte(8'h72, 1'b1);
        wait_drain("drain_load_run");

        // Framing error on a run command must not start a dump.
        f0 = frames_seen;
        send_byte(8'h72, 1'b0);
        repeat (30 * BIT) @(negedge clk);
        check("framing_error_no_dump", frames_seen - f0, 0);
        push_dump(32'h0001_0000, 32'h0001_0000, 32'h0002_0000);
        send_byte(8'h72, 1'b1);
        wait_drain("drain_after_framing");

        // Unknown command is ignored; HALT-only program dumps zeros.
        do_reset();
        f0 = frames_seen;
        send_byte(8'h41, 1'b1);
        repeat (30 * BIT) @(negedge clk);
        check("unknown_cmd_no_dump", frames_seen - f0, 0);
        send_byte(8'h6C, 1'b1);
        send_word(32'hFFFF_FFFF);
        push_dump(32'h0, 32'h0, 32'h0);
        send_byte(8'h72, 1'b1);
        wait_drain("drain_halt_only");

        // Signed immediate wrap and signed slt.
        do_reset();
        send_byte(8'h6C, 1'b1);
        send_word(32'h2401_FFFF);
        send_word(32'h2422_0001);
        send_word(32'h0001_182A);
        send_word(32'hFFFF_FFFF);
        push_dump(32'hFFFF_FFFF, 32'h0, 32'h0);
        send_byte(8'h72, 1'b1);
        wait_drain("drain_arith");

        // 70 increments loaded; only the first 64 fit, so r1 ends at 64.
        do_reset();
        send_byte(8'h6C, 1'b1);
        for (int i = 0; i < 70; i++) send_word(32'h2421_0001);
        send_word(32'hFFFF_FFFF);
        push_dump(32'h0000_0040, 32'h0, 32'h0);
        send_byte(8'h72, 1'b1);
        wait_drain("drain_overflow");

        f0 = frames_seen;
        repeat (30 * BIT) @(negedge clk);
        check("no_trailing_frames", frames_seen - f0, 0);
        check("tx_idle_at_end", o_tx, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
